// File: rtl/actor_firing_scheduler.sv
// Self-timed round-robin firing scheduler for a dataflow actor graph.
// Optional WAIT-state watchdog enabled by defining ACTOR_SCHED_WATCHDOG_EN.
module actor_firing_scheduler #(
   parameter int NUM_ACTORS   = 4,
   parameter int CNT_WIDTH    = 16,
   parameter int QUIET_CYCLES = 8,
   parameter int WDOG_CYCLES  = 255
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_ACTORS-1:0]         in_ready,
   input  logic [NUM_ACTORS-1:0]         out_space,
   input  logic [NUM_ACTORS-1:0]         firing_done,
   output logic [NUM_ACTORS-1:0]         invoke,
   output logic [$clog2(NUM_ACTORS)-1:0] current,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_WIDTH-1:0]          firing_count,
   output logic                          timeout
);

   localparam int IW = $clog2(NUM_ACTORS);
   localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
   localparam logic [NUM_ACTORS-1:0] ONE_HOT0 = NUM_ACTORS'(1);

   typedef enum logic [2:0] {IDLE, SCAN, FIRE, WAIT, DONE} state_t;

   state_t                state_q;
   logic [IW-1:0]         ptr_q;
   logic [IW-1:0]         current_q;
   logic [7:0]            quiet_q;
   logic [NUM_ACTORS-1:0] invoke_q;
   logic [CNT_WIDTH-1:0]  count_q;

   logic [NUM_ACTORS-1:0] en;
   logic                  found;
   logic [IW-1:0]         winIdx;
   logic [IW-1:0]         cand;
   int                    idx;
   logic [IW-1:0]         ptr_d;
   logic [CNT_WIDTH-1:0]  count_d;

   // Rotating-priority search: first fireable actor at or above ptr, wrapping around.
   always_comb begin
      en     = in_ready & out_space;
      found  = 1'b0;
      winIdx = '0;
      idx    = 0;
      cand   = '0;
      for (int i = 0; i < NUM_ACTORS; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_ACTORS) idx = idx - NUM_ACTORS;
         cand = IW'(idx);
         if (!found && en[cand]) begin
            found  = 1'b1;
            winIdx = cand;
         end
      end
      ptr_d   = (current_q == IW'(NUM_ACTORS - 1)) ? '0 : current_q + 1'b1;
      count_d = (count_q == '1) ? count_q : count_q + 1'b1;
   end

`ifdef ACTOR_SCHED_WATCHDOG_EN
   localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
   logic [15:0] wdog_q;
   logic        timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         current_q <= '0;
         quiet_q   <= '0;
         invoke_q  <= '0;
         count_q   <= '0;
`ifdef ACTOR_SCHED_WATCHDOG_EN
         wdog_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         invoke_q <= '0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= SCAN;
                  count_q <= '0;
                  quiet_q <= '0;
`ifdef ACTOR_SCHED_WATCHDOG_EN
                  timeout_q <= 1'b0;
`endif
               end
            end
            SCAN: begin
               if (found) begin
                  current_q <= winIdx;
                  quiet_q   <= '0;
                  invoke_q  <= ONE_HOT0 << winIdx;
                  state_q   <= FIRE;
               end else begin
                  quiet_q <= quiet_q + 8'd1;
                  if (quiet_q == QUIET_LAST) state_q <= DONE;
               end
            end
            FIRE: begin
               state_q <= WAIT;
`ifdef ACTOR_SCHED_WATCHDOG_EN
               wdog_q  <= '0;
`endif
            end
            WAIT: begin
               // A completion on the same cycle as the watchdog limit counts as a normal firing.
               if (firing_done[current_q]) begin
                  ptr_q   <= ptr_d;
                  count_q <= count_d;
                  state_q <= SCAN;
               end
`ifdef ACTOR_SCHED_WATCHDOG_EN
               else if (wdog_q == WDOG_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  wdog_q <= wdog_q + 16'd1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign invoke       = invoke_q;
   assign current      = current_q;
   assign firing_count = count_q;
   assign busy         = (state_q == SCAN) || (state_q == FIRE) || (state_q == WAIT);
   assign done         = (state_q == DONE);

endmodule

// File: tb/tb_actor_firing_scheduler.sv
// Directed bench for actor_firing_scheduler: firing table plus reset, quiescence,
// done-filtering and watchdog sequences.
module tb_actor_firing_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  in_ready = '0;
   logic [3:0]  out_space = '0;
   logic [3:0]  firing_done = '0;
   logic [3:0]  invoke;
   logic [1:0]  current;
   logic        busy;
   logic        done;
   logic [15:0] firing_count;
   logic        timeout;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0]  inReady;
      logic [3:0]  outSpace;
      logic [3:0]  expInvoke;
      logic [15:0] expCount;
   } vec_t;

   vec_t vecs[11];

   actor_firing_scheduler #(
      .NUM_ACTORS(4), .CNT_WIDTH(16), .QUIET_CYCLES(8), .WDOG_CYCLES(10)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .in_ready(in_ready), .out_space(out_space), .firing_done(firing_done),
      .invoke(invoke), .current(current), .busy(busy), .done(done),
      .firing_count(firing_count), .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and sample just after the edge; invoke must never be multi-hot.
   task automatic tick();
      @(posedge clock);
      #1;
      checkOutput("invoke_onehot0", 32'($onehot0(invoke)), 32'd1);
   endtask

   task automatic waitInvoke(input logic [3:0] expInv, input string name);
      int n = 0;
      while (invoke == '0 && n < 20) begin
         tick();
         n++;
      end
      checkOutput(name, 32'(invoke), 32'(expInv));
   endtask

   // Completes the firing currently in FIRE; returns with the DUT back in SCAN.
   task automatic applyStimulus(input logic [3:0] expInv, input logic [15:0] expCnt, input string name);
      waitInvoke(expInv, name);
      firing_done = invoke;
      tick();
      tick();
      firing_done = '0;
      checkOutput({name, "_count"}, 32'(firing_count), 32'(expCnt));
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic startRun();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{4'hF, 4'hF, 4'b0001, 16'd1};
      vecs[1]  = '{4'hF, 4'hF, 4'b0010, 16'd2};
      vecs[2]  = '{4'hF, 4'hF, 4'b0100, 16'd3};
      vecs[3]  = '{4'hF, 4'hF, 4'b1000, 16'd4};
      vecs[4]  = '{4'hF, 4'hF, 4'b0001, 16'd5};
      vecs[5]  = '{4'b0101, 4'b0111, 4'b0100, 16'd6};
      vecs[6]  = '{4'b0101, 4'b0111, 4'b0001, 16'd7};
      vecs[7]  = '{4'b0101, 4'b0111, 4'b0100, 16'd8};
      vecs[8]  = '{4'b0101, 4'b0111, 4'b0001, 16'd9};
      vecs[9]  = '{4'b1000, 4'b1111, 4'b1000, 16'd10};
      vecs[10] = '{4'b0110, 4'b1110, 4'b0010, 16'd11};

      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_invoke", 32'(invoke), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_count", 32'(firing_count), 32'd0);
      checkOutput("rst_timeout", 32'(timeout), 32'd0);

      // Round-robin and gating table.
      in_ready  = vecs[0].inReady;
      out_space = vecs[0].outSpace;
      startRun();
      checkOutput("start_busy", 32'(busy), 32'd1);
      for (int v = 0; v < 11; v++) begin
         in_ready  = vecs[v].inReady;
         out_space = vecs[v].outSpace;
         applyStimulus(vecs[v].expInvoke, vecs[v].expCount, $sformatf("vec%0d", v));
      end

      // Reset in the middle of WAIT with arbitrary inputs.
      in_ready = 4'hF;
      out_space = 4'hF;
      waitInvoke(4'b0100, "t1_invoke");
      tick();
      in_ready    = 4'($urandom);
      out_space   = 4'($urandom);
      firing_done = 4'($urandom) & 4'b1011;
      doReset();
      firing_done = '0;
      checkOutput("t1_invoke", 32'(invoke), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd0);
      checkOutput("t1_done", 32'(done), 32'd0);
      checkOutput("t1_count", 32'(firing_count), 32'd0);
      checkOutput("t1_current", 32'(current), 32'd0);

      // Quiescence after two firings.
      in_ready = 4'hF;
      out_space = 4'hF;
      startRun();
      applyStimulus(4'b0001, 16'd1, "t4_f0");
      applyStimulus(4'b0010, 16'd2, "t4_f1");
      in_ready = '0;
      for (int c = 0; c < 7; c++) tick();
      checkOutput("t4_done_early", 32'(done), 32'd0);
      tick();
      checkOutput("t4_done", 32'(done), 32'd1);
      checkOutput("t4_busy", 32'(busy), 32'd0);
      checkOutput("t4_count", 32'(firing_count), 32'd2);
      startRun();
      checkOutput("t4_restart_busy", 32'(busy), 32'd1);
      checkOutput("t4_restart_count", 32'(firing_count), 32'd0);

      // Only the current actor's firing_done ends WAIT.
      in_ready = 4'b0010;
      waitInvoke(4'b0010, "t5_invoke1");
      tick();
      firing_done = 4'b0100;
      tick();
      tick();
      firing_done = '0;
      in_ready = 4'hF;
      checkOutput("t5_still_busy", 32'(busy), 32'd1);
      checkOutput("t5_count_hold", 32'(firing_count), 32'd0);
      firing_done = 4'b0010;
      tick();
      firing_done = '0;
      checkOutput("t5_count", 32'(firing_count), 32'd1);
      applyStimulus(4'b0100, 16'd2, "t5_invoke2");

      // Watchdog: never complete the next firing.
      waitInvoke(4'b1000, "t6_invoke");
`ifdef ACTOR_SCHED_WATCHDOG_EN
      for (int c = 0; c < 10; c++) tick();
      checkOutput("t6_busy_pre", 32'(busy), 32'd1);
      checkOutput("t6_timeout_pre", 32'(timeout), 32'd0);
      tick();
      checkOutput("t6_timeout", 32'(timeout), 32'd1);
      checkOutput("t6_done", 32'(done), 32'd1);
      checkOutput("t6_count", 32'(firing_count), 32'd2);
`else
      for (int c = 0; c < 50; c++) tick();
      checkOutput("t6_busy", 32'(busy), 32'd1);
      checkOutput("t6_timeout", 32'(timeout), 32'd0);
      checkOutput("t6_done", 32'(done), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
